perf_trace_monitor: RTL and testbench
=====================================

Name: perf_trace_monitor

Overview:
- Synthesizable run controller, performance counter and state-dump sequencer for the pipelined CPU.
- Counts cycles, stalls, flushes and retired instructions while the CPU runs.
- Raises a halt after a programmable cycle budget.
- On request, streams a snapshot over a valid/ready port: counters and PC, then the register file, then the first data-memory words. This moves the per-cycle bookkeeping out of simulation into reusable hardware for FPGA runs.

Parameters:
- CNT_W, 32: counter width, 1..32; counters zero-extend to 32 on output.
- NUM_REGS, 32: register-file entries dumped, 1..32.
- DMEM_WORDS, 8: 32-bit data-memory words dumped from address 0, 1..64.
- MAX_CYCLES, 15: cycle budget before halt; 0 = unlimited.
- AUTO_DUMP, 1: 1 = start a dump automatically on the halt rising edge.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  CPU start; counting enabled only while high
- stall_i  in  1  hazard-unit stall
- branch_i  in  1  branch decoded in ID; a stall with branch is not counted
- flush_i  in  1  pipeline flush
- retire_i  in  1  instruction written back this cycle
- pc_i  in  32  current PC
- halt_o  out  1  cycle budget reached; sticky until reset
- dump_req_i  in  1  request a dump; single-cycle pulse or level
- reg_raddr_o  out  5  register-file read address (combinational read)
- reg_rdata_i  in  32  register-file read data
- dmem_raddr_o  out  32  byte address of data-memory word (combinational read, little-endian word)
- dmem_rdata_i  in  32  data-memory read data
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer ready
- out_tag_o  out  2  0 = header, 1 = register, 2 = memory
- out_idx_o  out  6  index within tag
- out_data_o  out  32  beat payload
- out_last_o  out  1  final beat of dump
- busy_o  out  1  dump in progress
- done_o  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset:
  - All counters are 0, halt_o=0, FSM=IDLE.
  - out_valid_o=0, out_last_o=0, busy_o=0, done_o=0.
  - out_tag_o, out_idx_o and out_data_o are 0.
  - reg_raddr_o and dmem_raddr_o are 0.
- Counting applies in cycles where start_i=1 and halt_o=0:
  - cycle_cnt increments by 1.
  - stall_cnt increments if stall_i and not branch_i.
  - flush_cnt increments if flush_i.
  - retire_cnt increments if retire_i.
  - All counters saturate at 2^CNT_W-1; there is no wrap.
- Halt:
  - halt_o goes high on the clock edge at which cycle_cnt becomes MAX_CYCLES (MAX_CYCLES≠0).
  - Counting stops and halt_o holds until reset.
  - Counting during a dump continues unless halted.
- Dump trigger:
  - dump_req_i sampled high in IDLE, or the halt rising edge when AUTO_DUMP=1, moves IDLE→HDR.
  - On that edge a snapshot is taken of the four counters and pc_i.
  - Requests while busy are ignored and are not queued.
- FSM: IDLE → HDR (5 beats) → REG (NUM_REGS beats) → MEM (DMEM_WORDS beats) → DONE (1 cycle, done_o=1) → IDLE.
- HDR payload by idx: 0 = cycle, 1 = stall, 2 = flush, 3 = retire, 4 = PC, all from the snapshot.
- REG: reg_raddr_o = idx; out_data_o = reg_rdata_i.
- MEM: dmem_raddr_o = 4·idx; out_data_o = dmem_rdata_i.
- Output register and handshake:
  - Each beat's data is loaded into an output register on the cycle the beat is presented.
  - out_valid_o rises the cycle after entering a state or after the previous handshake.
  - Beat 0 therefore appears 1 cycle after the trigger.
  - Once valid, tag, idx, data and last are held stable until out_valid_o & out_ready_i.
  - Data is registered at presentation; later changes of the read data do not alter a held beat.
  - With out_ready_i held high, beats issue back-to-back, one per cycle.
  - Total beats = 5+NUM_REGS+DMEM_WORDS.
- out_last_o=1 only on the final MEM beat.
- busy_o=1 from HDR through DONE inclusive.
- Reset mid-dump aborts to IDLE on the next edge; out_valid_o drops and no done_o pulse is produced.
- A trigger in the same cycle as rst_i is discarded.

Test Plan:
- Run at default params, start_i=1 with no events → halt_o rises at the edge where cycle_cnt=15. With AUTO_DUMP=1 the header shows cycle=15, stall=0, flush=0, retire=0.
- stall_i high for 3 cycles (one with branch_i=1) and flush_i pulsed twice before halt → header stall=2, flush=2.
- Registers preloaded x[i]=i·3, dmem word0=5, out_ready_i=1 → 45 consecutive beats:
  - tags 0×5, 1×32, 2×8.
  - REG beat idx 7 carries 21.
  - MEM beat idx 0 carries 5.
  - out_last_o only on beat 44; done_o pulses the cycle after it.
- out_ready_i low for 4 cycles at REG idx 3 → valid, idx=3 and data=9 held unchanged, then resume; no beat lost or duplicated.
- CNT_W=4, MAX_CYCLES=0, retire_i=1 for 20 cycles → cycle and retire saturate at 15; halt_o stays 0.
- rst_i asserted during REG idx 10 → next cycle busy_o=0, out_valid_o=0, counters 0, no done_o. A fresh dump_req_i then restarts from HDR idx 0.

Source files
------------

// File: rtl/perf_trace_monitor.sv
// perf_trace_monitor: run controller, saturating performance counters and a
// valid/ready state-dump sequencer (header, register file, data memory).
module perf_trace_monitor #(
    parameter int CNT_W      = 32,
    parameter int NUM_REGS   = 32,
    parameter int DMEM_WORDS = 8,
    parameter int MAX_CYCLES = 15,
    parameter int AUTO_DUMP  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        flush_i,
    input  logic        retire_i,
    input  logic [31:0] pc_i,
    output logic        halt_o,
    input  logic        dump_req_i,
    output logic [4:0]  reg_raddr_o,
    input  logic [31:0] reg_rdata_i,
    output logic [31:0] dmem_raddr_o,
    input  logic [31:0] dmem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [1:0]  out_tag_o,
    output logic [5:0]  out_idx_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [5:0] HDR_LAST = 6'd4;
    localparam logic [5:0] REG_LAST = 6'(NUM_REGS - 1);
    localparam logic [5:0] MEM_LAST = 6'(DMEM_WORDS - 1);

    // DRAIN holds the final beat until accepted; idx_q points at the next beat to load.
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_REG, S_MEM, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d, ret_q, ret_d;
    logic              halt_q, halt_d;
    logic [4:0][31:0]  snap_q, snap_d;
    logic              ov_q, ov_d, olast_q, olast_d;
    logic [1:0]        otag_q, otag_d;
    logic [5:0]        oidx_q, oidx_d;
    logic [31:0]       odata_q, odata_d;
    logic              cnt_en, trig, load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != {CNT_W{1'b1}}) ? v + CNT_W'(1) : v;
    endfunction

    // Counters advance only while running and not halted; halt latches at the budget.
    always_comb begin
        cnt_en = start_i && !halt_q;
        cyc_d  = sat_inc(cyc_q, cnt_en);
        stl_d  = sat_inc(stl_q, cnt_en && stall_i && !branch_i);
        fls_d  = sat_inc(fls_q, cnt_en && flush_i);
        ret_d  = sat_inc(ret_q, cnt_en && retire_i);
        halt_d = halt_q;
        if (cnt_en && MAX_CYCLES != 0 && 32'(cyc_d) == 32'(MAX_CYCLES))
            halt_d = 1'b1;
    end

    // Dump sequencer: next-beat pointer plus the output register load/release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        ov_d    = ov_q;
        olast_d = olast_q;
        otag_d  = otag_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        trig    = (state_q == S_IDLE) &&
                  (dump_req_i || (AUTO_DUMP != 0 && halt_d && !halt_q));
        load    = (state_q == S_HDR || state_q == S_REG || state_q == S_MEM) &&
                  (!ov_q || out_ready_i);
        if (ov_q && out_ready_i) begin
            ov_d    = 1'b0;
            olast_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    // Snapshot reflects the counters as updated on the trigger edge.
                    state_d   = S_HDR;
                    idx_d     = '0;
                    snap_d[0] = 32'(cyc_d);
                    snap_d[1] = 32'(stl_d);
                    snap_d[2] = 32'(fls_d);
                    snap_d[3] = 32'(ret_d);
                    snap_d[4] = pc_i;
                end
            end
            S_HDR, S_REG, S_MEM: begin
                if (load) begin
                    ov_d   = 1'b1;
                    oidx_d = idx_q;
                    idx_d  = idx_q + 6'd1;
                    if (state_q == S_HDR) begin
                        otag_d = 2'd0;
                        case (idx_q[2:0])
                            3'd0:    odata_d = snap_q[0];
                            3'd1:    odata_d = snap_q[1];
                            3'd2:    odata_d = snap_q[2];
                            3'd3:    odata_d = snap_q[3];
                            default: odata_d = snap_q[4];
                        endcase
                        if (idx_q == HDR_LAST) begin
                            state_d = S_REG;
                            idx_d   = '0;
                        end
                    end else if (state_q == S_REG) begin
                        otag_d  = 2'd1;
                        odata_d = reg_rdata_i;
                        if (idx_q == REG_LAST) begin
                            state_d = S_MEM;
                            idx_d   = '0;
                        end
                    end else begin
                        otag_d  = 2'd2;
                        odata_d = dmem_rdata_i;
                        if (idx_q == MEM_LAST) begin
                            olast_d = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: if (ov_q && out_ready_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and output register; reset wins over any same-cycle trigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cyc_q   <= '0;
            stl_q   <= '0;
            fls_q   <= '0;
            ret_q   <= '0;
            halt_q  <= 1'b0;
            snap_q  <= '0;
            ov_q    <= 1'b0;
            olast_q <= 1'b0;
            otag_q  <= '0;
            oidx_q  <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
            ret_q   <= ret_d;
            halt_q  <= halt_d;
            snap_q  <= snap_d;
            ov_q    <= ov_d;
            olast_q <= olast_d;
            otag_q  <= otag_d;
            oidx_q  <= oidx_d;
            odata_q <= odata_d;
        end
    end

    assign halt_o       = halt_q;
    assign reg_raddr_o  = (state_q == S_REG) ? idx_q[4:0] : 5'd0;
    assign dmem_raddr_o = (state_q == S_MEM) ? {24'd0, idx_q, 2'b00} : 32'd0;
    assign out_valid_o  = ov_q;
    assign out_tag_o    = otag_q;
    assign out_idx_o    = oidx_q;
    assign out_data_o   = odata_q;
    assign out_last_o   = olast_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_trace_monitor.sv
// Bench for perf_trace_monitor: reference model predicts counters, halt,
// busy/done and the full beat stream; a scoreboard checks accepted beats.
module tb_perf_trace_monitor;

    localparam int  NR   = 32;
    localparam int  DW   = 8;
    localparam int  MAXC = 15;
    localparam longint CMAX = 64'hFFFF_FFFF;

    typedef struct {
        logic [1:0]  tag;
        logic [5:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 0, stall = 0, branch = 0, flush = 0, retire = 0, dreq = 0, rdy = 0;
    logic [31:0] pc = '0;
    logic        halt, ov, olast, busy, done;
    logic [4:0]  raddr;
    logic [31:0] rdata, daddr, ddata, odata;
    logic [1:0]  otag;
    logic [5:0]  oidx;
    logic [31:0] regs [32];
    logic [31:0] dmem [64];

    assign rdata = regs[raddr];
    assign ddata = dmem[daddr[7:2]];

    perf_trace_monitor dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .retire_i(retire), .pc_i(pc), .halt_o(halt), .dump_req_i(dreq),
        .reg_raddr_o(raddr), .reg_rdata_i(rdata), .dmem_raddr_o(daddr), .dmem_rdata_i(ddata),
        .out_valid_o(ov), .out_ready_i(rdy), .out_tag_o(otag), .out_idx_o(oidx),
        .out_data_o(odata), .out_last_o(olast), .busy_o(busy), .done_o(done)
    );

    // Narrow-counter, unlimited-budget instance for saturation.
    logic        rst2 = 1'b1, start2 = 0, retire2 = 0, dreq2 = 0;
    logic        halt2, ov2, olast2, busy2, done2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2, daddr2, ddata2, odata2;
    logic [1:0]  otag2;
    logic [5:0]  oidx2;
    localparam logic [31:0] PC2 = 32'h1234_5678;

    assign rdata2 = regs[raddr2];
    assign ddata2 = dmem[daddr2[7:2]];

    perf_trace_monitor #(.CNT_W(4), .NUM_REGS(2), .DMEM_WORDS(1), .MAX_CYCLES(0), .AUTO_DUMP(0)) dut2 (
        .clk_i(clk), .rst_i(rst2), .start_i(start2), .stall_i(1'b0), .branch_i(1'b0),
        .flush_i(1'b0), .retire_i(retire2), .pc_i(PC2), .halt_o(halt2), .dump_req_i(dreq2),
        .reg_raddr_o(raddr2), .reg_rdata_i(rdata2), .dmem_raddr_o(daddr2), .dmem_rdata_i(ddata2),
        .out_valid_o(ov2), .out_ready_i(1'b1), .out_tag_o(otag2), .out_idx_o(oidx2),
        .out_data_o(odata2), .out_last_o(olast2), .busy_o(busy2), .done_o(done2)
    );

    int     tot = 0, bad = 0, tick_no = 0;
    longint m_cyc, m_stl, m_fls, m_ret;
    bit     m_halt = 0, m_busy = 0, m_done = 0;
    beat_t  expq[$];
    beat_t  capq[$];
    int     acc_tick[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Expected dump contents, taken from the model's counters and memories.
    task automatic build_dump();
        beat_t b;
        longint h [5];
        h = '{m_cyc, m_stl, m_fls, m_ret, longint'(pc)};
        for (int i = 0; i < 5; i++) begin
            b = '{tag: 2'd0, idx: 6'(i), data: 32'(h[i]), last: 1'b0};
            expq.push_back(b);
        end
        for (int i = 0; i < NR; i++) begin
            b = '{tag: 2'd1, idx: 6'(i), data: regs[i], last: 1'b0};
            expq.push_back(b);
        end
        for (int i = 0; i < DW; i++) begin
            b = '{tag: 2'd2, idx: 6'(i), data: dmem[i], last: (i == DW - 1)};
            expq.push_back(b);
        end
    endtask

    // One clock: score the handshake due at the next edge, advance the model, then check.
    task automatic tick();
        bit hs, hs_last, idle_pre, rise, pv;
        beat_t b, held;
        hs = ov && rdy && !rst;
        hs_last = 0;
        if (hs) begin
            if (expq.size() == 0) chk("spurious_beat", 1, 0);
            else begin
                b = expq.pop_front();
                chk("beat_tag", otag, b.tag);
                chk("beat_idx", oidx, b.idx);
                chk("beat_data", odata, b.data);
                chk("beat_last", olast, b.last);
                capq.push_back('{tag: otag, idx: oidx, data: odata, last: olast});
                acc_tick.push_back(tick_no);
                hs_last = (expq.size() == 0);
            end
        end
        if (rst) begin
            m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
            m_halt = 0; m_busy = 0; m_done = 0;
            expq.delete();
        end else begin
            idle_pre = !m_busy;
            if (m_done) m_busy = 0;
            m_done = hs_last;
            rise = 0;
            if (start && !m_halt) begin
                m_cyc = sat(m_cyc + 1);
                if (stall && !branch) m_stl = sat(m_stl + 1);
                if (flush)  m_fls = sat(m_fls + 1);
                if (retire) m_ret = sat(m_ret + 1);
                if (m_cyc == MAXC) begin m_halt = 1; rise = 1; end
            end
            if (idle_pre && (dreq || rise)) begin
                m_busy = 1;
                build_dump();
            end
        end
        pv   = ov && !hs && !rst;
        held = '{tag: otag, idx: oidx, data: odata, last: olast};
        @(negedge clk);
        tick_no++;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("halt", halt, m_halt);
        if (!m_busy) chk("idle_valid", ov, 0);
        if (pv) begin
            chk("hold_valid", ov, 1);
            chk("hold_tag", otag, held.tag);
            chk("hold_idx", oidx, held.idx);
            chk("hold_data", odata, held.data);
            chk("hold_last", olast, held.last);
        end
    endtask

    task automatic quiet();
        start = 0; stall = 0; branch = 0; flush = 0; retire = 0; dreq = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        tick();
        rst = 0;
        capq.delete();
        acc_tick.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || expq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", (m_busy || expq.size() != 0), 0);
    endtask

    task automatic wait_beat(input logic [1:0] t, input logic [5:0] i);
        int n = 0;
        while (!(ov && otag == t && oidx == i) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_beat_timeout", (ov && otag == t && oidx == i), 1);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        for (int i = 0; i < 64; i++) dmem[i] = 32'(100 + i);
        dmem[0] = 32'd5;
    endtask

    initial begin
        int n_tag [3];
        int n_last, last_pos, nb2;
        logic [31:0] cap2 [8];
        bit last2_ok, done2_seen;

        fill_pattern();
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_valid", ov, 0);   chk("rst_last", olast, 0);
        chk("rst_tag", otag, 0);   chk("rst_idx", oidx, 0);
        chk("rst_data", odata, 0); chk("rst_raddr", raddr, 0);
        chk("rst_daddr", daddr, 0);

        // Budget halt with auto dump, back-to-back stream
        rdy = 1;
        start = 1;
        for (int c = 1; c <= MAXC; c++) begin
            pc = $urandom;
            tick();
            if (c == MAXC - 1) chk("halt_before_budget", halt, 0);
        end
        chk("halt_at_budget", halt, 1);
        wait_idle(200);
        chk("s1_beats", capq.size(), 45);
        if (capq.size() == 45) begin
            chk("s1_hdr_cycle", capq[0].data, 15);
            chk("s1_hdr_stall", capq[1].data, 0);
            chk("s1_hdr_flush", capq[2].data, 0);
            chk("s1_hdr_retire", capq[3].data, 0);
            chk("s1_reg7", capq[12].data, 21);
            chk("s1_mem0", capq[37].data, 5);
            n_tag = '{0, 0, 0};
            n_last = 0; last_pos = -1;
            foreach (capq[k]) begin
                n_tag[capq[k].tag]++;
                if (capq[k].last) begin n_last++; last_pos = k; end
            end
            chk("s1_tag0", n_tag[0], 5);
            chk("s1_tag1", n_tag[1], 32);
            chk("s1_tag2", n_tag[2], 8);
            chk("s1_last_count", n_last, 1);
            chk("s1_last_pos", last_pos, 44);
            chk("s1_back_to_back", acc_tick[44] - acc_tick[0], 44);
        end
        chk("s1_halt_sticky", halt, 1);

        // Stall/branch/flush accounting
        do_reset();
        start = 1;
        for (int c = 1; c <= MAXC; c++) begin
            stall  = (c >= 2 && c <= 4);
            branch = (c == 3);
            flush  = (c == 6 || c == 9);
            tick();
        end
        quiet();
        wait_idle(200);
        if (capq.size() >= 4) begin
            chk("s2_hdr_cycle", capq[0].data, 15);
            chk("s2_hdr_stall", capq[1].data, 2);
            chk("s2_hdr_flush", capq[2].data, 2);
        end else chk("s2_beats", capq.size(), 45);

        // Backpressure at register idx 3; read data changes under the held beat
        do_reset();
        start = 1;
        wait_beat(2'd1, 6'd3);
        rdy = 0;
        regs[3] = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) tick();
        chk("s4_hold_valid", ov, 1);
        chk("s4_hold_idx", oidx, 3);
        chk("s4_hold_data", odata, 9);
        rdy = 1;
        wait_idle(200);
        chk("s4_beats", capq.size(), 45);
        fill_pattern();

        // Reset in the middle of the register phase, then a fresh request
        do_reset();
        start = 1;
        wait_beat(2'd1, 6'd10);
        rst = 1;
        tick();
        rst = 0;
        chk("s6_valid_after_rst", ov, 0);
        chk("s6_busy_after_rst", busy, 0);
        start = 0;
        tick(); tick();
        capq.delete();
        pc = 32'hCAFE_0000;
        dreq = 1;
        tick();
        dreq = 0;
        wait_idle(200);
        chk("s6_beats", capq.size(), 45);
        if (capq.size() == 45) begin
            chk("s6_first_tag", capq[0].tag, 0);
            chk("s6_first_idx", capq[0].idx, 0);
            chk("s6_hdr_cycle", capq[0].data, 0);
            chk("s6_hdr_pc", capq[4].data, 32'hCAFE_0000);
        end

        // Random traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            for (int i = 0; i < 64; i++) dmem[i] = $urandom;
            for (int c = 0; c < 300; c++) begin
                start  = ($urandom_range(0, 3) != 0);
                stall  = ($urandom_range(0, 2) == 0);
                branch = ($urandom_range(0, 3) == 0);
                flush  = ($urandom_range(0, 4) == 0);
                retire = $urandom_range(0, 1);
                dreq   = ($urandom_range(0, 19) == 0);
                rdy    = ($urandom_range(0, 2) != 0);
                pc     = $urandom;
                tick();
            end
            quiet();
            rdy = 1;
            wait_idle(200);
        end

        // Narrow counters saturate, no budget halt
        do_reset();
        rst2 = 1;
        tick();
        rst2 = 0;
        start2 = 1; retire2 = 1;
        for (int c = 0; c < 20; c++) tick();
        start2 = 0; retire2 = 0;
        chk("sat_halt", halt2, 0);
        dreq2 = 1;
        tick();
        dreq2 = 0;
        nb2 = 0; last2_ok = 1; done2_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (ov2) begin
                if (nb2 < 8) cap2[nb2] = odata2;
                if (olast2 != (nb2 == 7)) last2_ok = 0;
                nb2++;
            end
            if (done2) done2_seen = 1;
            tick();
        end
        chk("sat_beats", nb2, 8);
        chk("sat_last", last2_ok, 1);
        chk("sat_done", done2_seen, 1);
        if (nb2 == 8) begin
            chk("sat_cycle", cap2[0], 15);
            chk("sat_stall", cap2[1], 0);
            chk("sat_retire", cap2[3], 15);
            chk("sat_pc", cap2[4], PC2);
            chk("sat_reg1", cap2[6], regs[1]);
            chk("sat_mem0", cap2[7], dmem[0]);
        end
        chk("sat_halt_end", halt2, 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
